// File: rtl/spkid_pipe_pkg.sv
// Shared definitions for the spike/frame-marker pipe scheduler.
// Contents: word-format constants, write-arbiter state type and word-build helpers.
package spkid_pipe_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned MARKER_BIT = 15;
    localparam int unsigned FRAME_W    = 15;
    localparam int unsigned DROP_W     = 16;

    typedef enum logic [0:0] {
        IDLE,
        MARK_PEND
    } arb_state_e;

    // Marker word: MSB set, low bits carry the frame number.
    function automatic logic [WORD_W-1:0] build_marker(input logic [FRAME_W-1:0] frame);
        logic [WORD_W-1:0] w;
        w             = {1'b0, frame};
        w[MARKER_BIT] = 1'b1;
        return w;
    endfunction

    // Spike word: MSB clear, zero-extended neuron id below it.
    function automatic logic [WORD_W-1:0] build_spike(input logic [FRAME_W-1:0] id);
        return {1'b0, id};
    endfunction

endpackage

// File: rtl/spkid_fifo_sync.sv
// Single-clock FIFO with registered read data, occupancy count and full/empty.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_wr_en, i_wr_data   write request; accepted when not full or when a pop frees a slot
//   i_rd_en              pop request; ignored when empty
//   o_rd_data            head word, valid the cycle after a pop, held otherwise
//   o_count              words stored; o_count_next is the value after this cycle
//   o_full, o_empty      occupancy flags
//   o_push, o_pop        this cycle's accepted write / pop
module spkid_fifo_sync #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic [DEPTH_LOG2:0]   o_count_next,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_push,
    output logic                  o_pop
);

    localparam int unsigned        DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [WIDTH-1:0]      r_rd_data;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_count_next;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_pop     = i_rd_en && !o_empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign w_push    = i_wr_en && (!o_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_push       = w_push;
    assign o_pop        = w_pop;

endmodule

// File: rtl/spkid_pipe_scheduler.sv
// Merges spike events and frame markers into one 16-bit word stream, buffers it and
// paces it out to the host pipe-out with block-granular ready and drop accounting.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_enable                  write side enable; reads are always served
//   i_spk_valid, i_spk_id     spike strobe and neuron id
//   i_frame_tick              frame boundary pulse
//   i_rd_en, o_rd_data        pipe-out read strobe and data (1-cycle latency)
//   o_block_ready             at least BLOCK_WORDS words stored
//   o_fifo_count              words stored
//   o_drop_cnt, o_overflow    saturating drop count, sticky drop flag
//   o_underflow               sticky read-while-empty flag
module spkid_pipe_scheduler
    import spkid_pipe_pkg::*;
#(
    parameter int unsigned NN          = 8,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_spk_valid,
    input  logic [NN+2:0]         i_spk_id,
    input  logic                  i_frame_tick,
    input  logic                  i_rd_en,
    output logic [WORD_W-1:0]     o_rd_data,
    output logic                  o_block_ready,
    output logic [DEPTH_LOG2:0]   o_fifo_count,
    output logic [DROP_W-1:0]     o_drop_cnt,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam logic [DEPTH_LOG2:0] BLOCK_CNT = (DEPTH_LOG2+1)'(BLOCK_WORDS);

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    logic [FRAME_W-1:0]  r_frame_cnt;
    logic [DROP_W-1:0]   r_drop_cnt;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_block_ready;

    logic                w_want;
    logic                w_is_marker;
    logic [WORD_W-1:0]   w_word;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic [DEPTH_LOG2:0] w_count;
    logic [DEPTH_LOG2:0] w_count_next;

    // Write arbiter: a coincident spike goes first (it closes the old frame), marker follows.
    always_comb begin
        w_state_next = r_state;
        w_want       = 1'b0;
        w_is_marker  = 1'b0;
        w_word       = build_spike(FRAME_W'(i_spk_id));
        if (!i_enable) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_spk_valid) begin
                        w_want = 1'b1;
                        if (i_frame_tick) begin
                            w_state_next = MARK_PEND;
                        end
                    end else if (i_frame_tick) begin
                        w_want      = 1'b1;
                        w_is_marker = 1'b1;
                        w_word      = build_marker(r_frame_cnt);
                    end
                end
                MARK_PEND: begin
                    // A tick seen here is a protocol error and is dropped silently.
                    w_want       = 1'b1;
                    w_is_marker  = 1'b1;
                    w_word       = build_marker(r_frame_cnt);
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    spkid_fifo_sync #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_wr_en      (w_want),
        .i_wr_data    (w_word),
        .i_rd_en      (i_rd_en),
        .o_rd_data    (o_rd_data),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_push       (w_push),
        .o_pop        (w_pop)
    );

    assign w_drop = w_want && !w_push;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_frame_cnt   <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_block_ready <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_block_ready <= (w_count_next >= BLOCK_CNT);
            // Frame numbering advances even for a dropped marker so gaps stay visible.
            if (w_want && w_is_marker) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
                end
            end
            if (i_rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_block_ready = r_block_ready;
    assign o_fifo_count  = w_count;
    assign o_drop_cnt    = r_drop_cnt;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;

endmodule
